// File: rtl/serial_adder_pkg.sv
// serial_adder shared types, helpers and parameter check.
// Optional feature macro: SERIAL_ADDER_OVF_EN (adds ovf output).
package serial_adder_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

`ifndef SERIAL_ADDER_CHECK
`define SERIAL_ADDER_CHECK(W, D) \
  if ((W) < 1 || (D) < 1 || ((W) % (D)) != 0) begin : g_bad_params \
    $error("serial_adder: DIGIT must divide WIDTH"); \
  end
`endif

// File: rtl/serial_adder_if.sv
// serial_adder start/busy/done handshake and operand bundle.
// Optional feature macro: SERIAL_ADDER_OVF_EN (adds ovf).
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
`else
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
`endif
endinterface

// File: rtl/serial_adder_fa_cell.sv
// serial_adder one-bit full adder cell.
// Chained DIGIT times to form the per-cycle ripple.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder, DIGIT bits per clock.
// Optional feature macro: SERIAL_ADDER_OVF_EN (signed overflow).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  `SERIAL_ADDER_CHECK(WIDTH, DIGIT)

  localparam int NSTEPS = WIDTH / DIGIT;
  localparam int SW     = clog2(NSTEPS);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [SW-1:0]    step;
  logic             last;
  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] s_d;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             done_q;

  assign last = (step == SW'(NSTEPS - 1));
  assign c[0] = carry;

  for (genvar i = 0; i < DIGIT; i++) begin : g_chain
    fa_cell u_fa (
      .a  (a_sr[i]),
      .b  (b_sr[i]),
      .ci (c[i]),
      .s  (s_d[i]),
      .co (c[i+1])
    );
  end

  if (NSTEPS == 1) begin : g_single
    assign res = s_d;
  end else begin : g_acc
    logic [WIDTH-DIGIT-1:0] acc;

    assign res = {s_d, acc};

    // Partial digits enter at the MSB side and drift down.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc <= '0;
      end else if (state == ST_RUN) begin
        acc <= res[WIDTH-1:DIGIT];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: idle until start, run until last step.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (bus.start) state_nxt = ST_RUN;
      ST_RUN:  if (last) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, digit stepping and result commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      carry  <= 1'b0;
      step   <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            carry <= bus.cin;
            step  <= '0;
          end
        end
        ST_RUN: begin
          a_sr  <= a_sr >> DIGIT;
          b_sr  <= b_sr >> DIGIT;
          carry <= c[DIGIT];
          step  <= step + 1'b1;
          if (last) begin
            sum_q  <= res;
            cout_q <= c[DIGIT];
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;

  // Signed overflow: carry into MSB differs from carry out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state == ST_RUN && last) begin
      ovf_q <= c[DIGIT-1] ^ c[DIGIT];
    end
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.busy = (state == ST_RUN);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// serial_adder scoreboard bench: three configurations.
// Optional feature macro: SERIAL_ADDER_OVF_EN (checks ovf).
module tb_serial_adder;

  logic clk;
  logic rst_n;
  int   cyc;
  int   ncmp;
  int   nfail;

  typedef struct {
    logic [7:0] s;
    logic       co;
    logic       ov;
    int         c;
  } exp_t;

  exp_t q8a[$];
  exp_t q8b[$];
  exp_t q4[$];

  serial_adder_if #(.WIDTH(8)) i8a ();
  serial_adder_if #(.WIDTH(8)) i8b ();
  serial_adder_if #(.WIDTH(4)) i4 ();

  serial_adder #(.WIDTH(8), .DIGIT(1)) u8a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (i8a.slave)
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u8b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (i8b.slave)
  );

  serial_adder #(.WIDTH(4), .DIGIT(2)) u4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (i4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    ncmp++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // Issue one start from a negedge; optionally score it.
  task automatic go(input int sel,
                    input logic [7:0] a, input logic [7:0] b,
                    input logic cin, input bit push,
                    input logic [7:0] es, input logic eco,
                    input logic eov);
    exp_t e;
    case (sel)
      0: begin i8a.a = a; i8a.b = b; i8a.cin = cin; i8a.start = 1'b1; end
      1: begin i8b.a = a; i8b.b = b; i8b.cin = cin; i8b.start = 1'b1; end
      default: begin
        i4.a = a[3:0]; i4.b = b[3:0]; i4.cin = cin; i4.start = 1'b1;
      end
    endcase
    @(posedge clk);
    #1;
    i8a.start = 1'b0;
    i8b.start = 1'b0;
    i4.start  = 1'b0;
    e.s  = es;
    e.co = eco;
    e.ov = eov;
    if (push) begin
      case (sel)
        0: begin e.c = cyc + 8; q8a.push_back(e); end
        1: begin e.c = cyc + 2; q8b.push_back(e); end
        default: begin e.c = cyc + 2; q4.push_back(e); end
      endcase
    end
  endtask

  task automatic wait_empty(input string nm);
    int k;
    k = 0;
    @(negedge clk);
    while ((q8a.size() + q8b.size() + q4.size()) != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      ncmp++;
      nfail++;
      $display("FAIL %s_timeout: got no done, expected done", nm);
      q8a.delete();
      q8b.delete();
      q4.delete();
    end
  endtask

  // Scoreboard monitors, one per instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && i8a.done) begin
      if (q8a.size() == 0) begin
        chk("u8a_extra_done", 1, 0);
      end else begin
        e = q8a.pop_front();
        chk("u8a_sum", {23'd0, i8a.cout, i8a.sum}, {23'd0, e.co, e.s});
        chk("u8a_lat", cyc, e.c);
        chk("u8a_busy_at_done", {31'd0, i8a.busy}, 0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("u8a_ovf", {31'd0, i8a.ovf}, {31'd0, e.ov});
`endif
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && i8b.done) begin
      if (q8b.size() == 0) begin
        chk("u8b_extra_done", 1, 0);
      end else begin
        e = q8b.pop_front();
        chk("u8b_sum", {23'd0, i8b.cout, i8b.sum}, {23'd0, e.co, e.s});
        chk("u8b_lat", cyc, e.c);
`ifdef SERIAL_ADDER_OVF_EN
        chk("u8b_ovf", {31'd0, i8b.ovf}, {31'd0, e.ov});
`endif
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && i4.done) begin
      if (q4.size() == 0) begin
        chk("u4_extra_done", 1, 0);
      end else begin
        e = q4.pop_front();
        chk("u4_sum", {27'd0, i4.cout, i4.sum}, {27'd0, e.co, e.s[3:0]});
        chk("u4_lat", cyc, e.c);
`ifdef SERIAL_ADDER_OVF_EN
        chk("u4_ovf", {31'd0, i4.ovf}, {31'd0, e.ov});
`endif
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [4:0] s5;
    logic [3:0] av;
    logic [3:0] bv;
    logic       ov;
    cyc   = 0;
    ncmp  = 0;
    nfail = 0;
    rst_n = 1'b0;
    i8a.start = 1'b0; i8a.a = '0; i8a.b = '0; i8a.cin = 1'b0;
    i8b.start = 1'b0; i8b.a = '0; i8b.b = '0; i8b.cin = 1'b0;
    i4.start  = 1'b0; i4.a  = '0; i4.b  = '0; i4.cin  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {29'd0, i8a.busy, i8b.busy, i4.busy}, 0);
    chk("rst_done", {29'd0, i8a.done, i8b.done, i4.done}, 0);
    chk("rst_sum", {12'd0, i8a.sum, i8b.sum, i4.sum}, 0);
    chk("rst_cout", {29'd0, i8a.cout, i8b.cout, i4.cout}, 0);
    rst_n = 1'b1;

    // FF + 01: wraps to 00 with carry out.
    go(0, 8'hFF, 8'h01, 1'b0, 1, 8'h00, 1'b1, 1'b0);
    chk("u8a_busy_after_start", {31'd0, i8a.busy}, 1);
    wait_empty("t1");

    // 3C + 5A + 1 = 97; second start mid-run is ignored.
    go(0, 8'h3C, 8'h5A, 1'b1, 1, 8'h97, 1'b0, 1'b1);
    @(negedge clk);
    go(0, 8'h00, 8'h00, 1'b0, 0, 8'h00, 1'b0, 1'b0);
    chk("u8a_busy_ignored_start", {31'd0, i8a.busy}, 1);
    wait_empty("t2");
    repeat (12) @(negedge clk);

    // DIGIT=4: A5 + 6E = 113, then restart while done is high.
    go(1, 8'hA5, 8'h6E, 1'b0, 1, 8'h13, 1'b1, 1'b0);
    k = 0;
    @(negedge clk);
    while (!i8b.done && k < 20) begin
      @(negedge clk);
      k++;
    end
    go(1, 8'h01, 8'h01, 1'b0, 1, 8'h02, 1'b0, 1'b0);
    wait_empty("t3");

    // Signed overflow vectors.
    go(1, 8'h7F, 8'h01, 1'b0, 1, 8'h80, 1'b0, 1'b1);
    wait_empty("t4a");
    go(1, 8'hFF, 8'h01, 1'b0, 1, 8'h00, 1'b1, 1'b0);
    wait_empty("t4b");

    // Reset mid-operation aborts without a done pulse.
    go(0, 8'hF0, 8'h0F, 1'b0, 0, 8'h00, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, i8a.busy}, 0);
    chk("abort_done", {31'd0, i8a.done}, 0);
    chk("abort_sum", {23'd0, i8a.cout, i8a.sum}, 0);
    repeat (2) @(negedge clk);
    chk("abort_held_sum", {23'd0, i8a.cout, i8a.sum}, 0);
    rst_n = 1'b1;
    go(0, 8'h01, 8'h02, 1'b0, 1, 8'h03, 1'b0, 1'b0);
    wait_empty("t5");

    // Exhaustive WIDTH=4, DIGIT=2 sweep.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int ci = 0; ci < 2; ci++) begin
          av = 4'(a);
          bv = 4'(b);
          s5 = 5'(a + b + ci);
          ov = (av[3] == bv[3]) && (s5[3] != av[3]);
          go(2, 8'(a), 8'(b), 1'(ci), 1, {4'd0, s5[3:0]}, s5[4], ov);
          wait_empty("sweep");
        end
      end
    end

    repeat (12) @(negedge clk);
    chk("left_over", q8a.size() + q8b.size() + q4.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
